// File: rtl/aes_key_sync_dispatcher_if.sv
// dvr_key_if: key + sync block handoff toward the AES encryptor.
// Ports: valid/key/sync from master, rdy from slave.
interface dvr_key_if #(
    parameter int W = 128
);
    logic         valid;
    logic         rdy;
    logic [W-1:0] key;
    logic [W-1:0] sync;

    modport master (output valid, output key, output sync, input rdy);
    modport slave  (input valid, input key, input sync, output rdy);
endinterface

// File: rtl/aes_key_sync_dispatcher.sv
// aes_key_sync_dispatcher: offers {key, sync} to the encryptor once per message.
// Ports: clk, rst (sync active-low), cfg_valid/cfg_key/cfg_iv/cfg_rdy load path,
//        msg_done end-of-message pulse, key_and_sync master port,
//        msgs_keyed, exhausted, protocol_err status.
module aes_key_sync_dispatcher #(
    parameter int DATA_WIDTH_IN_BYTES = 16,
    parameter int CNT_WIDTH           = 32,
    parameter int MAX_MSGS            = 1024
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             cfg_valid,
    input  logic [8*DATA_WIDTH_IN_BYTES-1:0] cfg_key,
    input  logic [8*DATA_WIDTH_IN_BYTES-1:0] cfg_iv,
    output logic                             cfg_rdy,
    input  logic                             msg_done,
    dvr_key_if.master                        key_and_sync,
    output logic [CNT_WIDTH-1:0]             msgs_keyed,
    output logic                             exhausted,
    output logic                             protocol_err
);
    localparam int W     = 8 * DATA_WIDTH_IN_BYTES;
    localparam int IDX_W = $clog2(MAX_MSGS + 1);

    localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(MAX_MSGS);
    // Selects the per-message counter field at the bottom of sync.
    localparam logic [W-1:0] LO_MASK = {W{1'b1}} >> (W - CNT_WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        OFFER,
        WAIT_MSG_END,
        EXHAUSTED
    } state_t;

    state_t               state_q;
    logic [W-1:0]         key_q;
    logic [W-1:0]         iv_q;
    logic [IDX_W-1:0]     idx_q;
    logic                 valid_q;
    logic                 cfg_rdy_q;
    logic [W-1:0]         key_out_q;
    logic [W-1:0]         sync_out_q;
    logic [CNT_WIDTH-1:0] keyed_q;
    logic                 exh_q;
    logic                 perr_q;

    logic                 cfg_take;
    logic [W-1:0]         key_d;
    logic [W-1:0]         iv_d;
    logic [IDX_W-1:0]     idx_d;
    logic                 offer_d;

    // The counter field wraps on its own; bits above it never see a carry.
    function automatic logic [W-1:0] sync_for(input logic [W-1:0]     iv,
                                              input logic [IDX_W-1:0] idx);
        logic [W-1:0] sum;
        sum = iv + W'(idx);
        return (iv & ~LO_MASK) | (sum & LO_MASK);
    endfunction

    // A load in the same cycle as msg_done must feed the very next offer.
    always_comb begin
        cfg_take = cfg_valid & cfg_rdy_q;
        key_d    = cfg_take ? cfg_key : key_q;
        iv_d     = cfg_take ? cfg_iv  : iv_q;
        idx_d    = cfg_take ? '0      : idx_q;
        offer_d  = 1'b0;
        case (state_q)
            IDLE:         offer_d = cfg_take;
            EXHAUSTED:    offer_d = cfg_take;
            WAIT_MSG_END: offer_d = msg_done && (idx_d < MAX_IDX);
            default:      offer_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            key_q      <= '0;
            iv_q       <= '0;
            idx_q      <= '0;
            valid_q    <= 1'b0;
            cfg_rdy_q  <= 1'b1;
            key_out_q  <= '0;
            sync_out_q <= '0;
            keyed_q    <= '0;
            exh_q      <= 1'b0;
            perr_q     <= 1'b0;
        end else begin
            key_q <= key_d;
            iv_q  <= iv_d;
            idx_q <= idx_d;
            if (cfg_take) keyed_q <= '0;
            if (msg_done && state_q != WAIT_MSG_END) perr_q <= 1'b1;

            if (state_q == OFFER && key_and_sync.rdy) begin
                idx_q     <= idx_q + IDX_W'(1);
                keyed_q   <= keyed_q + CNT_WIDTH'(1);
                valid_q   <= 1'b0;
                cfg_rdy_q <= 1'b1;
                state_q   <= WAIT_MSG_END;
            end

            if (state_q == WAIT_MSG_END && msg_done && !offer_d) begin
                exh_q   <= 1'b1;
                state_q <= EXHAUSTED;
            end

            if (offer_d) begin
                state_q    <= OFFER;
                valid_q    <= 1'b1;
                cfg_rdy_q  <= 1'b0;
                exh_q      <= 1'b0;
                key_out_q  <= key_d;
                sync_out_q <= sync_for(iv_d, idx_d);
            end
        end
    end

    assign key_and_sync.valid = valid_q;
    assign key_and_sync.key   = key_out_q;
    assign key_and_sync.sync  = sync_out_q;
    assign cfg_rdy            = cfg_rdy_q;
    assign msgs_keyed         = keyed_q;
    assign exhausted          = exh_q;
    assign protocol_err       = perr_q;
endmodule

// File: tb/tb_aes_key_sync_dispatcher.sv
// Bench for aes_key_sync_dispatcher: directed table, reset corner,
// then random traffic checked against a transaction-level model.
module tb_aes_key_sync_dispatcher;
    localparam int W   = 128;
    localparam int MAX = 3;

    logic         clk;
    logic         rst;
    logic         cfg_valid;
    logic [W-1:0] cfg_key;
    logic [W-1:0] cfg_iv;
    logic         cfg_rdy;
    logic         msg_done;
    logic [31:0]  msgs_keyed;
    logic         exhausted;
    logic         protocol_err;

    dvr_key_if #(.W(W)) ks ();

    aes_key_sync_dispatcher #(
        .DATA_WIDTH_IN_BYTES(16),
        .CNT_WIDTH(32),
        .MAX_MSGS(MAX)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cfg_valid(cfg_valid),
        .cfg_key(cfg_key),
        .cfg_iv(cfg_iv),
        .cfg_rdy(cfg_rdy),
        .msg_done(msg_done),
        .key_and_sync(ks),
        .msgs_keyed(msgs_keyed),
        .exhausted(exhausted),
        .protocol_err(protocol_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [W-1:0] got,
                       input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [W-1:0] model_sync(input logic [W-1:0] iv,
                                                input int n);
        logic [31:0] lo;
        lo = iv[31:0] + n[31:0];
        return {iv[W-1:32], lo};
    endfunction

    typedef struct {
        logic         cv;
        logic         ksel;
        logic         rdy;
        logic         md;
        logic         e_valid;
        logic         e_crdy;
        logic         e_exh;
        logic         e_perr;
        logic [31:0]  e_keyed;
        logic         chk_ks;
        logic [W-1:0] e_key;
        logic [W-1:0] e_sync;
    } vec_t;

    localparam logic [W-1:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [W-1:0] IV1 = 128'hffffffff_ffffffff_ffffffff_fffffffe;
    localparam logic [W-1:0] S1  = 128'hffffffff_ffffffff_ffffffff_ffffffff;
    localparam logic [W-1:0] S2  = 128'hffffffff_ffffffff_ffffffff_00000000;
    localparam logic [W-1:0] K2  = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
    localparam logic [W-1:0] IV2 = 128'h01234567_89abcdef_00112233_44556677;

    vec_t tbl[19];

    // Random-phase model: transaction view of the key stream.
    bit           loaded;
    bit           awaiting;
    bit           m_exh;
    bit           m_perr;
    int           n;
    logic [W-1:0] ck;
    logic [W-1:0] civ;

    initial begin
        tbl[0]  = '{1,0,0,0, 1,0,0,0, 0, 1,K1,IV1};
        for (int i = 1; i <= 5; i++)
            tbl[i] = '{0,0,0,0, 1,0,0,0, 0, 1,K1,IV1};
        tbl[6]  = '{0,0,1,0, 0,1,0,0, 1, 0,'0,'0};
        tbl[7]  = '{0,0,1,0, 0,1,0,0, 1, 0,'0,'0};
        tbl[8]  = '{0,0,0,1, 1,0,0,0, 1, 1,K1,S1};
        tbl[9]  = '{0,0,1,0, 0,1,0,0, 2, 0,'0,'0};
        tbl[10] = '{0,0,0,1, 1,0,0,0, 2, 1,K1,S2};
        tbl[11] = '{0,0,1,0, 0,1,0,0, 3, 0,'0,'0};
        tbl[12] = '{0,0,0,1, 0,1,1,0, 3, 0,'0,'0};
        tbl[13] = '{0,0,1,0, 0,1,1,0, 3, 0,'0,'0};
        tbl[14] = '{1,1,0,0, 1,0,0,0, 0, 1,K2,IV2};
        tbl[15] = '{0,0,1,0, 0,1,0,0, 1, 0,'0,'0};
        tbl[16] = '{1,0,0,1, 1,0,0,0, 0, 1,K1,IV1};
        tbl[17] = '{0,0,0,1, 1,0,0,1, 0, 1,K1,IV1};
        tbl[18] = '{0,0,0,0, 1,0,0,1, 0, 1,K1,IV1};

        rst       = 1'b0;
        cfg_valid = 1'b0;
        cfg_key   = '0;
        cfg_iv    = '0;
        msg_done  = 1'b0;
        ks.rdy    = 1'b0;
        tick();
        tick();
        chk("rst_valid", ks.valid, 0);
        chk("rst_crdy", cfg_rdy, 1);
        chk("rst_keyed", msgs_keyed, 0);
        chk("rst_exh", exhausted, 0);
        chk("rst_perr", protocol_err, 0);
        chk("rst_key", ks.key, 0);
        chk("rst_sync", ks.sync, 0);
        rst = 1'b1;
        tick();

        for (int i = 0; i < 19; i++) begin
            cfg_valid = tbl[i].cv;
            cfg_key   = tbl[i].ksel ? K2 : K1;
            cfg_iv    = tbl[i].ksel ? IV2 : IV1;
            ks.rdy    = tbl[i].rdy;
            msg_done  = tbl[i].md;
            tick();
            chk($sformatf("t%0d_valid", i), ks.valid, tbl[i].e_valid);
            chk($sformatf("t%0d_crdy", i), cfg_rdy, tbl[i].e_crdy);
            chk($sformatf("t%0d_exh", i), exhausted, tbl[i].e_exh);
            chk($sformatf("t%0d_perr", i), protocol_err, tbl[i].e_perr);
            chk($sformatf("t%0d_keyed", i), msgs_keyed, tbl[i].e_keyed);
            if (tbl[i].chk_ks) begin
                chk($sformatf("t%0d_key", i), ks.key, tbl[i].e_key);
                chk($sformatf("t%0d_sync", i), ks.sync, tbl[i].e_sync);
            end
        end

        // Reset while an offer is up and rdy is high: no handshake.
        cfg_valid = 1'b0;
        msg_done  = 1'b0;
        ks.rdy    = 1'b1;
        rst       = 1'b0;
        tick();
        chk("mid_rst_valid", ks.valid, 0);
        chk("mid_rst_crdy", cfg_rdy, 1);
        chk("mid_rst_keyed", msgs_keyed, 0);
        chk("mid_rst_exh", exhausted, 0);
        chk("mid_rst_perr", protocol_err, 0);
        chk("mid_rst_key", ks.key, 0);
        chk("mid_rst_sync", ks.sync, 0);
        rst    = 1'b1;
        ks.rdy = 1'b0;
        tick();
        chk("post_rst_valid", ks.valid, 0);

        loaded   = 0;
        awaiting = 0;
        m_exh    = 0;
        m_perr   = 0;
        n        = 0;
        ck       = '0;
        civ      = '0;
        for (int c = 0; c < 4000; c++) begin
            bit           ev;
            bit           pre_aw;
            bit           do_rst;
            bit           r;
            bit           md;
            bit           cv;
            logic [W-1:0] nk;
            logic [W-1:0] niv;

            ev = loaded && !awaiting && !m_exh;
            chk("r_valid", ks.valid, ev);
            chk("r_crdy", cfg_rdy, !ev);
            chk("r_exh", exhausted, m_exh);
            chk("r_perr", protocol_err, m_perr);
            chk("r_keyed", msgs_keyed, n);
            if (ev) begin
                chk("r_key", ks.key, ck);
                chk("r_sync", ks.sync, model_sync(civ, n));
            end

            do_rst = ($urandom % 300) == 0;
            r      = $urandom % 2;
            md     = awaiting ? (($urandom % 3) == 0) : (($urandom % 40) == 0);
            cv     = ($urandom % 6) == 0;
            nk     = {$urandom, $urandom, $urandom, $urandom};
            niv    = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom % 2)
                niv[31:0] = 32'hffffffff - ($urandom % 3);

            rst       = !do_rst;
            ks.rdy    = r;
            msg_done  = md;
            cfg_valid = cv;
            cfg_key   = nk;
            cfg_iv    = niv;

            if (do_rst) begin
                loaded   = 0;
                awaiting = 0;
                m_exh    = 0;
                m_perr   = 0;
                n        = 0;
            end else begin
                pre_aw = awaiting;
                if (ev && r) begin
                    n++;
                    awaiting = 1;
                end
                if (cv && !ev) begin
                    ck     = nk;
                    civ    = niv;
                    n      = 0;
                    loaded = 1;
                    m_exh  = 0;
                end
                if (md && !pre_aw) m_perr = 1;
                if (md && pre_aw) begin
                    awaiting = 0;
                    if (n >= MAX) m_exh = 1;
                end
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
